// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath widths and writeback requester ids
package datapath_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter
// Round-robin on contest only; accepted write is registered one cycle later.
module regfile_wb_arbiter
  import datapath_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          rf_enw,
  output logic [AW-1:0] rf_rd_add,
  output logic [DW-1:0] rf_write_data,
  output logic          stall_out,
  output logic [15:0]   conflict_cnt
);

  req_id_t prio;
  logic    alu_acc;
  logic    mem_acc;
  logic    contest;

  // Ready looks only at the other channel's valid and prio, never at own data.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      alu_ready = !mem_valid || (prio == REQ_ALU);
      mem_ready = !alu_valid || (prio == REQ_MEM);
    end
    alu_acc   = alu_valid && alu_ready;
    mem_acc   = mem_valid && mem_ready;
    contest   = alu_valid && mem_valid;
    stall_out = (alu_valid && !alu_ready) || (mem_valid && !mem_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_enw        <= 1'b0;
      rf_rd_add     <= '0;
      rf_write_data <= '0;
      conflict_cnt  <= '0;
      prio          <= REQ_ALU;
    end else begin
      rf_enw <= 1'b0;
      if (alu_acc) begin
        rf_enw        <= (alu_rd != '0);
        rf_rd_add     <= alu_rd;
        rf_write_data <= alu_data;
      end else if (mem_acc) begin
        rf_enw        <= (mem_rd != '0);
        rf_rd_add     <= mem_rd;
        rf_write_data <= mem_data;
      end
      if (contest) begin
        prio <= (prio == REQ_ALU) ? REQ_MEM : REQ_ALU;
        if (conflict_cnt != 16'hFFFF) begin
          conflict_cnt <= conflict_cnt + 16'd1;
        end
      end
    end
  end

endmodule
